// File: rtl/sound_pkg.sv
// Shared definitions for the melody playback path: note period table,
// song entry field positions and the sequencer state encoding.
package sound_pkg;

  // Period in 50 MHz cycles of MIDI notes 0..11; higher octaves are right shifts.
  localparam logic [31:0] BASE_WL [0:11] = '{
    32'd6115610, 32'd5772367, 32'd5448389, 32'd5142595,
    32'd4853963, 32'd4581531, 32'd4324390, 32'd4081680,
    32'd3852593, 32'd3636364, 32'd3432270, 32'd3239632
  };

  localparam int unsigned END_BIT  = 15;
  localparam int unsigned NOTE_MSB = 14;
  localparam int unsigned NOTE_LSB = 8;
  localparam int unsigned DUR_MSB  = 7;
  localparam int unsigned DUR_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    HOLD   = 2'd3
  } seq_state_t;

endpackage

// File: rtl/note_period_lut.sv
// Combinational MIDI note to oscillator period conversion:
// split note into octave and pitch class, then shift the base period.
module note_period_lut
  import sound_pkg::*;
(
  input  logic [6:0]  note,
  output logic [31:0] wave_length
);

  logic [6:0] rem;
  logic [3:0] oct;

  // Ten conditional subtractions cover the full 0..127 note range.
  always_comb begin
    rem = note;
    oct = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (rem >= 7'd12) begin
        rem = rem - 7'd12;
        oct = oct + 4'd1;
      end
    end
    wave_length = BASE_WL[rem[3:0]] >> oct;
  end

endmodule

// File: rtl/note_sequencer.sv
// Song RAM plus playback FSM: fetches note entries, times their durations
// in ticks and drives the oscillator period and mute gate.
module note_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TICK_CYCLES = 500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [31:0]       wave_length,
  output logic              gate,
  output logic              playing,
  output logic              done,
  output logic [ADDR_W-1:0] note_addr
);

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [15:0]   mem [2**ADDR_W];
  logic [15:0]   rd_data;
  seq_state_t    state;
  logic [CW-1:0] cyc_cnt;
  logic [7:0]    tick_cnt;
  logic [31:0]   lut_wl;
  logic [6:0]    ent_note;
  logic [7:0]    ent_dur;

  assign ent_note = rd_data[NOTE_MSB:NOTE_LSB];
  assign ent_dur  = rd_data[DUR_MSB:DUR_LSB];

  // Read and write share one edge, so a same-address write returns old data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (state == FETCH) rd_data <= mem[note_addr];
  end

  note_period_lut u_lut (
    .note        (ent_note),
    .wave_length (lut_wl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wave_length <= '0;
      gate        <= 1'b0;
      playing     <= 1'b0;
      done        <= 1'b0;
      note_addr   <= '0;
      cyc_cnt     <= '0;
      tick_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state   <= IDLE;
        playing <= 1'b0;
        gate    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              note_addr <= '0;
              playing   <= 1'b1;
              state     <= FETCH;
            end
          end
          FETCH: state <= DECODE;
          DECODE: begin
            if (rd_data[END_BIT]) begin
              if (loop) begin
                note_addr <= '0;
                state     <= FETCH;
              end else begin
                done    <= 1'b1;
                gate    <= 1'b0;
                playing <= 1'b0;
                state   <= IDLE;
              end
            end else if (ent_dur == 8'd0) begin
              note_addr <= note_addr + ADDR_W'(1);
              state     <= FETCH;
            end else begin
              tick_cnt <= ent_dur;
              cyc_cnt  <= '0;
              if (ent_note != 7'd0) begin
                wave_length <= lut_wl;
                gate        <= 1'b1;
              end else begin
                gate <= 1'b0;
              end
              state <= HOLD;
            end
          end
          HOLD: begin
            if (cyc_cnt == CW'(TICK_CYCLES - 1)) begin
              cyc_cnt <= '0;
              if (tick_cnt == 8'd1) begin
                note_addr <= note_addr + ADDR_W'(1);
                state     <= FETCH;
              end else begin
                tick_cnt <= tick_cnt - 8'd1;
              end
            end else begin
              cyc_cnt <= cyc_cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
